// File: rtl/dac_uart_packet_parser.sv
// Framed UART command parser feeding the MCP4922 update controller; owns the 24x12-bit shadow bank.
// Optional ACK/NAK response through the UART transmitter when DAC_PKT_ACK_EN is defined.
module dac_uart_packet_parser #(
  parameter int unsigned NUM_CH         = 24,
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             uart_rx_data,
  input  logic                   uart_rx_valid,
  input  logic                   dac_busy,
  input  logic                   update_complete,
  output logic [NUM_CH*12-1:0]   all_channel_data,
  output logic [4:0]             target_channel,
  output logic [11:0]            single_dac_value,
  output logic                   update_single_channel,
  output logic                   update_all_channels,
  output logic [7:0]             err_count,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_start,
  input  logic                   uart_tx_busy
);

  localparam int unsigned DW    = 12;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_CH, S_DHI, S_DLO, S_CSUM, S_EXEC, S_ISSUE, S_WAIT
  } state_t;

  state_t           state, state_n;
  logic [7:0]       cmd_q, ch_q, dhi_q, dlo_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [DW-1:0]    value;
  logic             csum_ok, cmd_known, ch_bad, pkt_err, timeable, tmo_hit;
  logic             err_inc, wr_shadow, load_target, fire_single, fire_all, ack_ev, ack_ok;

  assign value     = {dhi_q[3:0], dlo_q};
  assign csum_ok   = ((cmd_q ^ ch_q ^ dhi_q ^ dlo_q) == uart_rx_data);
  assign cmd_known = (cmd_q == 8'h01) || (cmd_q == 8'h02) || (cmd_q == 8'h03);
  assign ch_bad    = ((cmd_q == 8'h01) || (cmd_q == 8'h02)) && (ch_q >= 8'(NUM_CH));
  assign pkt_err   = !csum_ok || (dhi_q[7:4] != 4'h0) || ch_bad || !cmd_known;
  assign timeable  = (state inside {S_CMD, S_CH, S_DHI, S_DLO, S_CSUM, S_WAIT});
  // A byte arriving in the timeout cycle always wins.
  assign tmo_hit   = timeable && !uart_rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (uart_rx_valid && (uart_rx_data == SYNC_BYTE)) state_n = S_CMD;
      S_CMD:   if (uart_rx_valid) state_n = S_CH;  else if (tmo_hit) state_n = S_IDLE;
      S_CH:    if (uart_rx_valid) state_n = S_DHI; else if (tmo_hit) state_n = S_IDLE;
      S_DHI:   if (uart_rx_valid) state_n = S_DLO; else if (tmo_hit) state_n = S_IDLE;
      S_DLO:   if (uart_rx_valid) state_n = S_CSUM; else if (tmo_hit) state_n = S_IDLE;
      S_CSUM:  if (uart_rx_valid) state_n = pkt_err ? S_IDLE : S_EXEC;
               else if (tmo_hit) state_n = S_IDLE;
      S_EXEC:  state_n = (cmd_q == 8'h02) ? S_IDLE : S_ISSUE;
      S_ISSUE: if (update_single_channel || update_all_channels) state_n = S_WAIT;
      S_WAIT:  if (update_complete || tmo_hit) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Strobes are registered: the request is decided one cycle ahead so it lands 2 cycles after CSUM.
  always_comb begin
    err_inc     = 1'b0;
    wr_shadow   = 1'b0;
    load_target = 1'b0;
    fire_single = 1'b0;
    fire_all    = 1'b0;
    ack_ev      = 1'b0;
    ack_ok      = 1'b0;
    case (state)
      S_CMD, S_CH, S_DHI, S_DLO: begin
        err_inc = tmo_hit;
        ack_ev  = tmo_hit;
      end
      S_CSUM: begin
        if (uart_rx_valid) begin
          ack_ev  = 1'b1;
          ack_ok  = !pkt_err;
          err_inc = pkt_err;
        end else begin
          err_inc = tmo_hit;
          ack_ev  = tmo_hit;
        end
      end
      S_EXEC: begin
        err_inc     = uart_rx_valid;
        wr_shadow   = (cmd_q != 8'h03);
        load_target = (cmd_q == 8'h01);
        fire_single = (cmd_q == 8'h01) && !dac_busy;
        fire_all    = (cmd_q == 8'h03) && !dac_busy;
      end
      S_ISSUE: begin
        err_inc     = uart_rx_valid;
        fire_single = (cmd_q == 8'h01) && !dac_busy && !update_single_channel;
        fire_all    = (cmd_q == 8'h03) && !dac_busy && !update_all_channels;
      end
      S_WAIT: begin
        err_inc = uart_rx_valid || (tmo_hit && !update_complete);
        ack_ev  = tmo_hit && !update_complete;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q                 <= '0;
      ch_q                  <= '0;
      dhi_q                 <= '0;
      dlo_q                 <= '0;
      tmo_cnt               <= '0;
      err_count             <= '0;
      update_single_channel <= 1'b0;
      update_all_channels   <= 1'b0;
      target_channel        <= '0;
      single_dac_value      <= '0;
      all_channel_data      <= '0;
    end else begin
      if (uart_rx_valid) begin
        case (state)
          S_CMD:   cmd_q <= uart_rx_data;
          S_CH:    ch_q  <= uart_rx_data;
          S_DHI:   dhi_q <= uart_rx_data;
          S_DLO:   dlo_q <= uart_rx_data;
          default: ;
        endcase
      end
      if (uart_rx_valid || (state_n != state) || !timeable) tmo_cnt <= '0;
      else                                                  tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      update_single_channel <= fire_single;
      update_all_channels   <= fire_all;
      if (load_target) begin
        target_channel   <= ch_q[4:0];
        single_dac_value <= value;
      end
      if (wr_shadow) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (ch_q == 8'(i)) all_channel_data[i*DW +: DW] <= value;
        end
      end
    end
  end

`ifdef DAC_PKT_ACK_EN
  logic ack_pend;

  // Single pending response slot; a newer verdict replaces an unsent one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_tx_data  <= '0;
      uart_tx_start <= 1'b0;
      ack_pend      <= 1'b0;
    end else begin
      uart_tx_start <= 1'b0;
      if (ack_ev) begin
        uart_tx_data <= ack_ok ? 8'h06 : 8'h15;
        ack_pend     <= 1'b1;
      end else if (ack_pend && !uart_tx_busy) begin
        uart_tx_start <= 1'b1;
        ack_pend      <= 1'b0;
      end
    end
  end
`else
  logic unused_ack;
  assign unused_ack    = ack_ev ^ ack_ok ^ uart_tx_busy;
  assign uart_tx_data  = '0;
  assign uart_tx_start = 1'b0;
`endif

endmodule

// File: tb/tb_dac_uart_packet_parser.sv
// Directed-vector bench for dac_uart_packet_parser (short timeout for simulation speed).
module tb_dac_uart_packet_parser;

  localparam int unsigned TMO = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   uart_rx_data;
  logic         uart_rx_valid;
  logic         dac_busy;
  logic         update_complete;
  logic [287:0] all_channel_data;
  logic [4:0]   target_channel;
  logic [11:0]  single_dac_value;
  logic         update_single_channel;
  logic         update_all_channels;
  logic [7:0]   err_count;
  logic [7:0]   uart_tx_data;
  logic         uart_tx_start;
  logic         uart_tx_busy;

  int           n_vec = 0;
  int           n_err = 0;
  int           n_single = 0;
  int           n_all = 0;
  int           n_tx = 0;
  logic [7:0]   last_tx = 8'h00;
  logic [287:0] bank_m;

  dac_uart_packet_parser #(.NUM_CH(24), .SYNC_BYTE(8'hAA), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .uart_rx_data          (uart_rx_data),
    .uart_rx_valid         (uart_rx_valid),
    .dac_busy              (dac_busy),
    .update_complete       (update_complete),
    .all_channel_data      (all_channel_data),
    .target_channel        (target_channel),
    .single_dac_value      (single_dac_value),
    .update_single_channel (update_single_channel),
    .update_all_channels   (update_all_channels),
    .err_count             (err_count),
    .uart_tx_data          (uart_tx_data),
    .uart_tx_start         (uart_tx_start),
    .uart_tx_busy          (uart_tx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update_single_channel) n_single++;
    if (update_all_channels)   n_all++;
    if (uart_tx_start) begin
      n_tx++;
      last_tx = uart_tx_data;
    end
  end

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was sampled.
  task automatic send(input logic [7:0] b);
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] ch,
                          input logic [7:0] dhi, input logic [7:0] dlo, input logic [7:0] cs);
    send(8'hAA); send(cmd); send(ch); send(dhi); send(dlo); send(cs);
  endtask

  task automatic complete();
    update_complete = 1'b1;
    @(negedge clk);
    update_complete = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_bank"}, all_channel_data, '0);
    check({tag, "_tgt"}, 288'(target_channel), 288'(0));
    check({tag, "_val"}, 288'(single_dac_value), 288'(0));
    check({tag, "_strb"}, 288'({update_single_channel, update_all_channels, uart_tx_start}), 288'(0));
    check({tag, "_err"}, 288'(err_count), 288'(0));
    check({tag, "_txd"}, 288'(uart_tx_data), 288'(0));
  endtask

  initial begin
    rst = 1'b1; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;
    dac_busy = 1'b0; update_complete = 1'b0; uart_tx_busy = 1'b0;
    bank_m = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // single-channel write and update, latency 2 cycles after CSUM
    send_pkt(8'h01, 8'h05, 8'h08, 8'h00, 8'h0C);
    check("t1_no_early_strobe", 288'(update_single_channel), 288'(0));
    @(negedge clk);
    bank_m[5*12 +: 12] = 12'h800;
    check("t1_strobe", 288'(update_single_channel), 288'(1));
    check("t1_tgt", 288'(target_channel), 288'(5));
    check("t1_val", 288'(single_dac_value), 288'(12'h800));
    check("t1_bank", all_channel_data, bank_m);
    @(negedge clk);
    check("t1_strobe_1cyc", 288'(update_single_channel), 288'(0));
    check("t1_err", 288'(err_count), 288'(0));
`ifdef DAC_PKT_ACK_EN
    check("t1_ack", 288'(last_tx), 288'(8'h06));
`endif
    complete();

    // bad checksum
    send_pkt(8'h01, 8'h05, 8'h08, 8'h00, 8'h0D);
    check("t2_err", 288'(err_count), 288'(1));
    repeat (3) @(negedge clk);
    check("t2_no_strobe", 288'(n_single), 288'(1));
    check("t2_bank", all_channel_data, bank_m);
`ifdef DAC_PKT_ACK_EN
    check("t2_nak", 288'(last_tx), 288'(8'h15));
`endif

    // channel out of range, shadow-only write, all-channel update
    send_pkt(8'h01, 8'h18, 8'h00, 8'h10, 8'h09);
    check("t3_ch24_err", 288'(err_count), 288'(2));
    send_pkt(8'h02, 8'h00, 8'h0F, 8'hFF, 8'hF2);
    repeat (3) @(negedge clk);
    bank_m[11:0] = 12'hFFF;
    check("t3_wr_bank", all_channel_data, bank_m);
    check("t3_wr_no_strobe", 288'({n_single[7:0], n_all[7:0]}), 288'({8'd1, 8'd0}));
    check("t3_wr_tgt_held", 288'(target_channel), 288'(5));
    send_pkt(8'h03, 8'h00, 8'h00, 8'h00, 8'h03);
    @(negedge clk);
    check("t3_all_strobe", 288'(update_all_channels), 288'(1));
    @(negedge clk);
    complete();
    check("t3_all_once", 288'(n_all), 288'(1));

    // DHI upper nibble set, unknown command, stray byte in IDLE
    send_pkt(8'h01, 8'h00, 8'h10, 8'h00, 8'h11);
    check("t3_dhi_err", 288'(err_count), 288'(3));
    send_pkt(8'h04, 8'h00, 8'h00, 8'h00, 8'h04);
    check("t3_cmd_err", 288'(err_count), 288'(4));
    send(8'h55);
    check("t3_idle_stray", 288'(err_count), 288'(4));

    // open-packet timeout boundary, then a normal packet
    send(8'hAA); send(8'h01);
    repeat (TMO - 1) @(negedge clk);
    check("t4_pre_tmo", 288'(err_count), 288'(4));
    @(negedge clk);
    check("t4_tmo", 288'(err_count), 288'(5));
`ifdef DAC_PKT_ACK_EN
    repeat (2) @(negedge clk);
    check("t4_nak", 288'(last_tx), 288'(8'h15));
`endif
    send_pkt(8'h01, 8'h03, 8'h01, 8'h23, 8'h20);
    @(negedge clk);
    bank_m[3*12 +: 12] = 12'h123;
    check("t4_strobe", 288'(update_single_channel), 288'(1));
    check("t4_val", 288'({target_channel, single_dac_value}), 288'({5'd3, 12'h123}));
    @(negedge clk);
    complete();

    // busy hold, dropped bytes during WAIT, WAIT timeout
    dac_busy = 1'b1;
    send_pkt(8'h01, 8'h07, 8'h0A, 8'hBC, 8'hB0);
    repeat (100) @(negedge clk);
    check("t5_busy_hold", 288'(n_single), 288'(2));
    dac_busy = 1'b0;
    @(negedge clk);
    bank_m[7*12 +: 12] = 12'hABC;
    check("t5_busy_fall_strobe", 288'(update_single_channel), 288'(1));
    check("t5_val", 288'({target_channel, single_dac_value}), 288'({5'd7, 12'hABC}));
    send(8'h55); send(8'h66);
    check("t5_drop_err", 288'(err_count), 288'(7));
    repeat (TMO - 1) @(negedge clk);
    check("t5_wait_pre_tmo", 288'(err_count), 288'(7));
    @(negedge clk);
    check("t5_wait_tmo", 288'(err_count), 288'(8));
    send_pkt(8'h02, 8'h05, 8'h00, 8'h00, 8'h07);
    @(negedge clk);
    bank_m[5*12 +: 12] = 12'h000;
    check("t5_after_tmo_bank", all_channel_data, bank_m);
    check("t5_after_tmo_err", 288'(err_count), 288'(8));

    // err_count saturation via a flood of dropped bytes
    send_pkt(8'h01, 8'h02, 8'h00, 8'h05, 8'h06);
    @(negedge clk);
    for (int i = 0; i < 260; i++) send(8'h5A);
    check("t5_err_sat", 288'(err_count), 288'(8'hFF));
    complete();

    // reset in the middle of a packet
    send(8'hAA); send(8'h01); send(8'h05);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("t6_reset");
    rst = 1'b0;
    bank_m = '0;
    @(negedge clk);
    send_pkt(8'h01, 8'h05, 8'h08, 8'h00, 8'h0C);
    @(negedge clk);
    bank_m[5*12 +: 12] = 12'h800;
    check("t6_strobe", 288'(update_single_channel), 288'(1));
    check("t6_bank", all_channel_data, bank_m);
    check("t6_val", 288'({target_channel, single_dac_value, err_count}), 288'({5'd5, 12'h800, 8'd0}));
    @(negedge clk);
    complete();

`ifndef DAC_PKT_ACK_EN
    check("tx_idle_cnt", 288'(n_tx), 288'(0));
    check("tx_idle_data", 288'(uart_tx_data), 288'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
